uart_tx_byte: RTL
=================

# uart_tx_byte

Serial transmitter that drains the byte stream produced by the change logger and sends it off-chip as 8N1/8E1/8O1/8N2 UART frames. Sits directly downstream of the logger. Consumes its `data`/`data_valid` pair and returns the one-cycle `next` acknowledge. Drives the host-facing `txd` pin.

## Interface
Parameters:
- CLKS_PER_BIT, 104: clock cycles per UART bit; legal range 1..65535.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- data  in  8  byte to send; valid while data_valid=1.
- data_valid  in  1  byte available; held until acknowledged.
- next  out  1  one-cycle acknowledge: byte in `data` has been taken.
- txd  out  1  serial output; idle high.
- busy  out  1  high from byte capture to end of last stop bit.

## Operation
- Reset values, applied asynchronously while rst_n=0:
  - txd=1, next=0, busy=0, state=IDLE.
  - Baud counter=0, bit counter=0.
- States: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE.
- IDLE: on an edge with data_valid=1:
  - load `data` into the shift register and compute the parity bit (even: ^data; odd: ~^data);
  - set next=1 and busy=1 for the following cycle;
  - go to START.
  - When data_valid=0, stay in IDLE.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: send 8 bits LSB first, each CLKS_PER_BIT cycles. A 3-bit counter selects the bit. After bit 7, go to PARITY or STOP.
- PARITY: txd=parity bit for CLKS_PER_BIT cycles.
- STOP: txd=1 for STOP_BITS×CLKS_PER_BIT cycles. At the end: busy=0, go to IDLE.
- data_valid is sampled only in IDLE. While busy, data_valid and data are ignored.
- next is never asserted outside the cycle after a capture.
- Baud counter: counts 0..CLKS_PER_BIT-1; its terminal count advances the bit. Width is clog2(CLKS_PER_BIT), minimum 1. It resets to 0 on capture.
- Reset mid-frame: the frame is aborted and txd returns high immediately. The captured byte is lost and not retransmitted.

## Timing
- Capture edge E (IDLE, data_valid=1).
- Cycle after E: next=1, txd=0 (start bit), busy=1. next=0 again one cycle later.
- Upstream handshake: the logger samples next&&data_valid at edge E+1 and drops data_valid. The transmitter does not look at data_valid again until IDLE.
- Frame length: (1 + 8 + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles from E+1.
- STOP→IDLE transition takes one edge, and IDLE needs one sampling cycle. Back-to-back frame period is therefore frame length + 1 cycle: one extra idle-high clock between frames.
- txd, next and busy are all registered outputs with no combinational path from inputs.
- CLKS_PER_BIT=1: each bit lasts exactly 1 cycle; the counter stays at 0.

## Structure
- Package uart_pkg:
  - state encoding constants: IDLE, START, DATA, PARITY, STOP;
  - parity mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
- Sub-module uart_baud_gen (parameter CLKS_PER_BIT):
  - inputs: clk, rst_n, restart;
  - output: one-cycle `tick` at terminal count.
- The transmitter FSM and shift register stay in uart_tx_byte.

## Test plan
- Single byte, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, data=0xA5:
  - next pulses exactly once, 1 cycle after capture;
  - txd holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles, then stays 1;
  - busy is high for 40 cycles.
- Parity, data=0xA5, PARITY=1: parity bit 0. With PARITY=2: parity bit 1. Frame is 44 cycles at CLKS_PER_BIT=4.
- Back-to-back stream with a logger model holding data_valid, bytes 0x01, 0x80, 0xFF:
  - three next pulses;
  - frame starts 41 cycles apart;
  - decoded bytes match in order.
- data_valid held high without next response across a whole frame:
  - exactly one next per frame;
  - no capture while busy.
- Async reset asserted mid-DATA of 0x3C:
  - txd=1, busy=0, next=0 in the same cycle;
  - after release with data_valid=1, a fresh frame starts with a full-length start bit.
- STOP_BITS=2, CLKS_PER_BIT=1, data=0x00: txd = 0 for 9 cycles, then 1 for 2 cycles; next frame can start only after one more idle cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encoding, parity modes and the parity helper for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Even mode makes the total count of ones even; odd mode makes it odd.
  function automatic logic parity_bit(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count with a one-cycle tick.
// restart forces the count back to 0 so every frame begins with a full-length bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/uart_tx_byte.sv
// UART transmitter: captures one byte per frame from the logger handshake and serialises it LSB first.
// txd, next and busy are registered; data_valid is only looked at while idle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       next,
  output logic       txd,
  output logic       busy
);

  import uart_pkg::*;

  state_t     state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       par, par_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       stop_cnt, stop_cnt_nxt;
  logic       txd_nxt, next_nxt, busy_nxt;
  logic       tick;

  // Holding the divider in restart while idle aligns the start bit to the capture edge.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(state == IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      par      <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      txd      <= 1'b1;
      next     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      par      <= par_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      txd      <= txd_nxt;
      next     <= next_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    par_nxt      = par;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    txd_nxt      = txd;
    next_nxt     = 1'b0;
    busy_nxt     = busy;

    unique case (state)
      IDLE: begin
        if (data_valid) begin
          shreg_nxt    = data;
          par_nxt      = parity_bit(data, PARITY);
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = 1'b0;
          txd_nxt      = 1'b0;
          next_nxt     = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = START;
        end
      end
      START: begin
        if (tick) begin
          txd_nxt   = shreg[0];
          shreg_nxt = {1'b0, shreg[7:1]};
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            if (PARITY != PAR_NONE) begin
              txd_nxt   = par;
              state_nxt = uart_pkg::PARITY;
            end else begin
              txd_nxt   = 1'b1;
              state_nxt = STOP;
            end
          end else begin
            txd_nxt     = shreg[0];
            shreg_nxt   = {1'b0, shreg[7:1]};
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          txd_nxt   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          // With two stop bits the first terminal count only marks the midpoint.
          if ((STOP_BITS == 2) && !stop_cnt) begin
            stop_cnt_nxt = 1'b1;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
